// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs a variable-latency req/ack read to instruction
// memory, hands the word to decode and stalls the controller until it arrives.
module instruction_fetch_unit #(
   parameter int unsigned            ADDR_WIDTH     = 32,
   parameter int unsigned            INST_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC       = '0,
   parameter int unsigned            TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_RequestState,
   input  logic                  fetch_ReceiveState,
   input  logic                  writebackState,
   input  logic                  pcUpdateValid,
   input  logic [ADDR_WIDTH-1:0] pcUpdateTarget,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [INST_WIDTH-1:0] mem_rdata,
   output logic [INST_WIDTH-1:0] instruction,
   output logic                  instructionValid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  fetchStall,
   output logic                  fetchFault
);

   localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_e;

   state_e                  state_q;
   logic                    mem_req_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [INST_WIDTH-1:0]   buffer_q;
   logic [INST_WIDTH-1:0]   instr_q;
   logic                    valid_q;
   logic                    fault_q;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    started_q, started_d;
   logic                    wb_fault;
   logic                    wb_clear_valid;

   // Writeback-time PC update. The controller resets into writeback, so the
   // first writeback after reset only arms the unit and must not advance pc.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      pc_d           = pc_q;
      started_d      = started_q;
      wb_fault       = 1'b0;
      wb_clear_valid = 1'b0;
      if (writebackState) begin
         if (!started_q) begin
            started_d = 1'b1;
         end else begin
            wb_clear_valid = 1'b1;
            if (!pcUpdateValid) begin
               pc_d = pc_q + ADDR_WIDTH'(4);
            end else if (pcUpdateTarget[1:0] == 2'b00) begin
               pc_d = pcUpdateTarget;
            end else begin
               wb_fault = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         mem_req_q <= 1'b0;
         cnt_q     <= '0;
         buffer_q  <= '0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
         pc_q      <= RESET_PC;
         started_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pc_q      <= pc_d;
         started_q <= started_d;
         if (wb_fault) fault_q <= 1'b1;

         unique case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (fetch_RequestState && !fault_q) begin
                  state_q   <= S_REQ;
                  mem_req_q <= 1'b1;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  buffer_q  <= mem_rdata;
                  state_q   <= S_DONE;
                  mem_req_q <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  fault_q   <= 1'b1;
                  state_q   <= S_IDLE;
                  mem_req_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (fetch_ReceiveState) begin
                  instr_q <= buffer_q;
                  valid_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // A writeback invalidates the word even if it coincides with a receive.
         if (wb_clear_valid) valid_q <= 1'b0;
      end
   end

   assign mem_req          = mem_req_q;
   assign mem_addr         = pc_q;
   assign pc               = pc_q;
   assign instruction      = instr_q;
   assign instructionValid = valid_q;
   assign fetchFault       = fault_q;
   // An idle unit (including a faulted one) never satisfies receive, so the core halts.
   assign fetchStall       = fetch_ReceiveState && (state_q != S_DONE);

endmodule
